// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan driver.
// Segment patterns are active-low {dp,g,f,e,d,c,b,a} with dp held off.
package seg_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_e;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Active-low one-hot anode for a digit index (3 = leftmost).
    function automatic logic [3:0] anode_onehot(input logic [1:0] idx);
        logic [3:0] one;
        one = 4'b0001 << idx;
        return ~one;
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// BCD to active-low seven-segment decode; codes 10-15 render blank.
// Purely combinational, no latency, no flow control.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/digit_scan_driver.sv
// Four-digit multiplexed 7-seg scan driver with shadowed digits, blink and blanking gaps.
// Outputs registered, updated on the edge that changes state/index; no backpressure.
// Optional SEG_LEADING_ZERO_BLANK_EN suppresses leading zeros on digits 3 and 2.
module digit_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_DIV    = 25000000
) (
    input  logic       in_clock,
    input  logic       in_reset_n,
    input  logic [3:0] in_digit3,
    input  logic [3:0] in_digit2,
    input  logic [3:0] in_digit1,
    input  logic [3:0] in_digit0,
    input  logic       in_update,
    input  logic [3:0] in_blink_mask,
    input  logic       in_enable,
    output logic [3:0] out_an,
    output logic [7:0] out_seg,
    output logic       out_update_ack,
    output logic       out_frame_start
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int BLK_W   = $clog2(BLINK_DIV);

    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_DIV - 1);

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic              phase_q, phase_d;
    logic [3:0][3:0]   shadow_q, shadow_d;
    logic [3:0][3:0]   active_q, active_d;
    logic              pending_q, pending_d;
    logic              ack_q, ack_d;
    logic              frame_q;
    logic [3:0]        an_q, an_d;
    logic [7:0]        seg_q, seg_d;

    logic              boundary;
    logic [3:0][3:0]   new_digits;
    logic [3:0]        sel_digit;
    logic [7:0]        dec_seg;

    assign new_digits = {in_digit3, in_digit2, in_digit1, in_digit0};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        boundary = 1'b0;
        if (!in_enable) begin
            state_d = OFF;
            idx_d   = 2'd3;
            cnt_d   = '0;
        end else begin
            case (state_q)
                OFF: begin
                    state_d = BLANK;
                    idx_d   = 2'd3;
                    cnt_d   = '0;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt_q == SCAN_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (idx_q == 2'd0) begin
                            idx_d    = 2'd3;
                            boundary = 1'b1;
                        end else begin
                            idx_d = idx_q - 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = OFF;
                    idx_d   = 2'd3;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    // Digits presented on the frame boundary itself bypass the shadow stage.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        ack_d     = 1'b0;
        if (boundary && in_update) begin
            shadow_d  = new_digits;
            active_d  = new_digits;
            pending_d = 1'b0;
            ack_d     = 1'b1;
        end else begin
            if ((boundary || state_q == OFF) && pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
                ack_d     = 1'b1;
            end
            if (in_update) begin
                shadow_d  = new_digits;
                pending_d = 1'b1;
            end
        end
    end

    always_comb begin
        sel_digit = active_d[idx_d];
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (idx_d == 2'd3 && active_d[3] == 4'd0) begin
            sel_digit = BLANK_CODE;
        end else if (idx_d == 2'd2 && active_d[3] == 4'd0 && active_d[2] == 4'd0) begin
            sel_digit = BLANK_CODE;
        end
`endif
    end

    seg_decoder u_seg_decoder (
        .digit_i (sel_digit),
        .seg_o   (dec_seg)
    );

    // Outputs follow the next state so they move on the same edge as the FSM.
    always_comb begin
        an_d  = 4'hF;
        seg_d = SEG_BLANK;
        if (state_d == DRIVE) begin
            an_d = anode_onehot(idx_d);
            if (!(in_blink_mask[idx_d] && !phase_d)) begin
                seg_d = dec_seg;
            end
        end
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q     <= OFF;
            idx_q       <= 2'd3;
            cnt_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            shadow_q    <= {4{BLANK_CODE}};
            active_q    <= {4{BLANK_CODE}};
            pending_q   <= 1'b0;
            ack_q       <= 1'b0;
            frame_q     <= 1'b0;
            an_q        <= 4'hF;
            seg_q       <= SEG_BLANK;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            ack_q       <= ack_d;
            frame_q     <= boundary;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign out_an          = an_q;
    assign out_seg         = seg_q;
    assign out_update_ack  = ack_q;
    assign out_frame_start = frame_q;

endmodule

// File: tb/tb_digit_scan_driver.sv
// Directed bench for digit_scan_driver with SCAN_DIV=4, BLANK_CYCLES=1, BLINK_DIV=16.
// A frame is 20 cycles: {blank, 4 x drive} for digits 3,2,1,0.
module tb_digit_scan_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] d3 = 4'd0, d2 = 4'd0, d1 = 4'd0, d0 = 4'd0;
    logic       upd = 1'b0;
    logic [3:0] mask = 4'd0;
    logic       en = 1'b1;
    logic [3:0] out_an;
    logic [7:0] out_seg;
    logic       out_update_ack;
    logic       out_frame_start;

    int checks = 0;
    int errors = 0;
    int unsigned kcnt;

    digit_scan_driver #(
        .SCAN_DIV     (4),
        .BLANK_CYCLES (1),
        .BLINK_DIV    (16)
    ) dut (
        .in_clock        (clk),
        .in_reset_n      (rst_n),
        .in_digit3       (d3),
        .in_digit2       (d2),
        .in_digit1       (d1),
        .in_digit0       (d0),
        .in_update       (upd),
        .in_blink_mask   (mask),
        .in_enable       (en),
        .out_an          (out_an),
        .out_seg         (out_seg),
        .out_update_ack  (out_update_ack),
        .out_frame_start (out_frame_start)
    );

    always #5 clk = ~clk;

    // Edges since reset release; blink phase is visible while bit 4 is clear.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) kcnt <= 0;
        else        kcnt <= kcnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            ok = out_frame_start;
        end
    endtask

    task automatic apply_update(input logic [3:0] a3, a2, a1, a0);
        d3 = a3; d2 = a2; d1 = a1; d0 = a0;
        upd = 1'b1;
        tick();
        upd = 1'b0;
    endtask

    function automatic logic [3:0] exp_an(input int s);
        int p;
        logic [3:0] one;
        p = s % 20;
        if (p % 5 == 0) return 4'hF;
        one = 4'b0001 << (3 - p / 5);
        return ~one;
    endfunction

    function automatic int exp_dig(input int s);
        int p;
        p = s % 20;
        if (p % 5 == 0) return -1;
        return 3 - p / 5;
    endfunction

    task automatic test_reset();
        bit ok;
        rst_n = 1'b0; en = 1'b1;
        repeat (3) tick();
        checks++;
        if (out_an !== 4'hF || out_seg !== 8'hFF || out_update_ack !== 1'b0 || out_frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_state an=%b seg=%h ack=%b fs=%b want 1111/ff/0/0", out_an, out_seg, out_update_ack, out_frame_start);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (out_an !== 4'hF || out_seg !== 8'hFF) begin
            errors++;
            $display("FAIL first_blank an=%b seg=%h want 1111/ff", out_an, out_seg);
        end
        tick();
        checks++;
        if (out_an !== 4'b0111 || out_seg !== 8'hFF) begin
            errors++;
            $display("FAIL first_drive an=%b seg=%h want 0111/ff", out_an, out_seg);
        end
        ok = 1'b1;
    endtask

    task automatic test_update();
        bit ok;
        logic [7:0] codes [4];
        codes[3] = 8'hF9; codes[2] = 8'hA4; codes[1] = 8'hB0; codes[0] = 8'h99;
        apply_update(4'd1, 4'd2, 4'd3, 4'd4);
        wait_frame(ok);
        checks++;
        if (!ok || out_update_ack !== 1'b1) begin
            errors++;
            $display("FAIL update_ack fs_seen=%b ack=%b want 1/1", ok, out_update_ack);
        end
        for (int s = 1; s <= 20; s++) begin
            int d;
            logic [7:0] eseg;
            tick();
            d = exp_dig(s);
            eseg = (d < 0) ? 8'hFF : codes[d];
            checks++;
            if (out_an !== exp_an(s) || out_seg !== eseg || out_update_ack !== 1'b0 ||
                out_frame_start !== (s == 20)) begin
                errors++;
                $display("FAIL update_seq s=%0d an=%b seg=%h ack=%b fs=%b want %b/%h/0/%b",
                         s, out_an, out_seg, out_update_ack, out_frame_start, exp_an(s), eseg, (s == 20));
            end
        end
    endtask

    task automatic test_overwrite();
        bit ok;
        apply_update(4'd1, 4'd1, 4'd1, 4'd1);
        apply_update(4'd9, 4'd9, 4'd9, 4'd9);
        wait_frame(ok);
        checks++;
        if (!ok || out_update_ack !== 1'b1) begin
            errors++;
            $display("FAIL overwrite_ack fs_seen=%b ack=%b want 1/1", ok, out_update_ack);
        end
        for (int s = 1; s <= 20; s++) begin
            logic [7:0] eseg;
            tick();
            eseg = (exp_dig(s) < 0) ? 8'hFF : 8'h90;
            checks++;
            if (out_an !== exp_an(s) || out_seg !== eseg || out_update_ack !== 1'b0) begin
                errors++;
                $display("FAIL overwrite_seq s=%0d an=%b seg=%h ack=%b want %b/%h/0",
                         s, out_an, out_seg, out_update_ack, exp_an(s), eseg);
            end
        end
    endtask

    task automatic test_decode();
        bit ok;
        logic [3:0] vin  [2][4];
        logic [7:0] vexp [2][4];
        vin[0][3] = 4'd6;  vin[0][2] = 4'd7;  vin[0][1] = 4'd8; vin[0][0] = 4'd9;
        vexp[0][3] = 8'h82; vexp[0][2] = 8'hF8; vexp[0][1] = 8'h80; vexp[0][0] = 8'h90;
        vin[1][3] = 4'd10; vin[1][2] = 4'd11; vin[1][1] = 4'd0; vin[1][0] = 4'd5;
        vexp[1][3] = 8'hFF; vexp[1][2] = 8'hFF; vexp[1][1] = 8'hC0; vexp[1][0] = 8'h92;
        for (int v = 0; v < 2; v++) begin
            apply_update(vin[v][3], vin[v][2], vin[v][1], vin[v][0]);
            wait_frame(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL decode_timeout vec=%0d no frame_start", v);
            end
            for (int s = 1; s <= 20; s++) begin
                int d;
                logic [7:0] eseg;
                tick();
                d = exp_dig(s);
                eseg = (d < 0) ? 8'hFF : vexp[v][d];
                checks++;
                if (out_an !== exp_an(s) || out_seg !== eseg) begin
                    errors++;
                    $display("FAIL decode vec=%0d s=%0d an=%b seg=%h want %b/%h", v, s, out_an, out_seg, exp_an(s), eseg);
                end
            end
        end
    endtask

    task automatic test_boundary_update();
        repeat (19) tick();
        d3 = 4'd3; d2 = 4'd3; d1 = 4'd3; d0 = 4'd3;
        upd = 1'b1;
        tick();
        upd = 1'b0;
        checks++;
        if (out_frame_start !== 1'b1 || out_update_ack !== 1'b1) begin
            errors++;
            $display("FAIL boundary_ack fs=%b ack=%b want 1/1", out_frame_start, out_update_ack);
        end
        for (int s = 1; s <= 20; s++) begin
            logic [7:0] eseg;
            tick();
            eseg = (exp_dig(s) < 0) ? 8'hFF : 8'hB0;
            checks++;
            if (out_an !== exp_an(s) || out_seg !== eseg || out_update_ack !== 1'b0) begin
                errors++;
                $display("FAIL boundary_seq s=%0d an=%b seg=%h ack=%b want %b/%h/0",
                         s, out_an, out_seg, out_update_ack, exp_an(s), eseg);
            end
        end
    endtask

    task automatic test_blink();
        bit ok;
        logic [7:0] codes [4];
        codes[3] = 8'hF9; codes[2] = 8'hA4; codes[1] = 8'hB0; codes[0] = 8'h99;
        apply_update(4'd1, 4'd2, 4'd3, 4'd4);
        wait_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL blink_timeout no frame_start");
        end
        mask = 4'b0011;
        for (int s = 1; s <= 80; s++) begin
            int d;
            bit vis;
            logic [7:0] eseg;
            tick();
            d = exp_dig(s);
            vis = ((kcnt / 16) % 2) == 0;
            eseg = (d < 0) ? 8'hFF : ((d < 2 && !vis) ? 8'hFF : codes[d]);
            checks++;
            if (out_an !== exp_an(s) || out_seg !== eseg) begin
                errors++;
                $display("FAIL blink s=%0d k=%0d an=%b seg=%h want %b/%h", s, kcnt, out_an, out_seg, exp_an(s), eseg);
            end
        end
        mask = 4'b0000;
    endtask

    task automatic test_enable_drop();
        bit ok;
        wait_frame(ok);
        tick(); tick();
        en = 1'b0;
        tick();
        checks++;
        if (!ok || out_an !== 4'hF || out_seg !== 8'hFF) begin
            errors++;
            $display("FAIL enable_drop fs_seen=%b an=%b seg=%h want 1/1111/ff", ok, out_an, out_seg);
        end
        repeat (3) tick();
        checks++;
        if (out_an !== 4'hF || out_seg !== 8'hFF) begin
            errors++;
            $display("FAIL enable_off an=%b seg=%h want 1111/ff", out_an, out_seg);
        end
        en = 1'b1;
        tick();
        checks++;
        if (out_an !== 4'hF || out_seg !== 8'hFF) begin
            errors++;
            $display("FAIL reenable_blank an=%b seg=%h want 1111/ff", out_an, out_seg);
        end
        for (int s = 1; s <= 5; s++) begin
            tick();
            checks++;
            if (out_an !== exp_an(s) || out_seg !== ((s == 5) ? 8'hFF : 8'hF9)) begin
                errors++;
                $display("FAIL reenable_drive s=%0d an=%b seg=%h want %b/%h", s, out_an, out_seg, exp_an(s), (s == 5) ? 8'hFF : 8'hF9);
            end
        end
    endtask

    task automatic test_off_apply();
        en = 1'b0;
        tick();
        d3 = 4'd2; d2 = 4'd2; d1 = 4'd2; d0 = 4'd2;
        upd = 1'b1;
        tick();
        upd = 1'b0;
        checks++;
        if (out_update_ack !== 1'b0) begin
            errors++;
            $display("FAIL off_ack_early ack=%b want 0", out_update_ack);
        end
        tick();
        checks++;
        if (out_update_ack !== 1'b1) begin
            errors++;
            $display("FAIL off_ack ack=%b want 1", out_update_ack);
        end
        tick();
        checks++;
        if (out_update_ack !== 1'b0) begin
            errors++;
            $display("FAIL off_ack_once ack=%b want 0", out_update_ack);
        end
        en = 1'b1;
        tick(); tick();
        checks++;
        if (out_an !== 4'b0111 || out_seg !== 8'hA4) begin
            errors++;
            $display("FAIL off_applied an=%b seg=%h want 0111/a4", out_an, out_seg);
        end
    endtask

    task automatic test_zero_blank();
        bit ok;
        logic [3:0] vin  [2][4];
        logic [7:0] vexp [2][4];
        logic [7:0] lz;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        lz = 8'hFF;
`else
        lz = 8'hC0;
`endif
        vin[0][3] = 4'd0; vin[0][2] = 4'd0; vin[0][1] = 4'd0; vin[0][0] = 4'd7;
        vexp[0][3] = lz; vexp[0][2] = lz; vexp[0][1] = 8'hC0; vexp[0][0] = 8'hF8;
        vin[1][3] = 4'd0; vin[1][2] = 4'd5; vin[1][1] = 4'd0; vin[1][0] = 4'd0;
        vexp[1][3] = lz; vexp[1][2] = 8'h92; vexp[1][1] = 8'hC0; vexp[1][0] = 8'hC0;
        for (int v = 0; v < 2; v++) begin
            apply_update(vin[v][3], vin[v][2], vin[v][1], vin[v][0]);
            wait_frame(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL zero_timeout vec=%0d no frame_start", v);
            end
            for (int s = 1; s <= 20; s++) begin
                int d;
                logic [7:0] eseg;
                tick();
                d = exp_dig(s);
                eseg = (d < 0) ? 8'hFF : vexp[v][d];
                checks++;
                if (out_an !== exp_an(s) || out_seg !== eseg) begin
                    errors++;
                    $display("FAIL zero_blank vec=%0d s=%0d an=%b seg=%h want %b/%h", v, s, out_an, out_seg, exp_an(s), eseg);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_update(4'd5, 4'd6, 4'd7, 4'd8);
        wait_frame(ok);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || out_an !== 4'hF || out_seg !== 8'hFF || out_update_ack !== 1'b0 || out_frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid fs_seen=%b an=%b seg=%h ack=%b fs=%b want 1/1111/ff/0/0",
                     ok, out_an, out_seg, out_update_ack, out_frame_start);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (out_an !== 4'hF || out_seg !== 8'hFF) begin
            errors++;
            $display("FAIL reset_mid_blank an=%b seg=%h want 1111/ff", out_an, out_seg);
        end
        tick();
        checks++;
        if (out_an !== 4'b0111 || out_seg !== 8'hFF) begin
            errors++;
            $display("FAIL reset_mid_drive an=%b seg=%h want 0111/ff", out_an, out_seg);
        end
        wait_frame(ok);
        checks++;
        if (!ok || out_update_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_noack fs_seen=%b ack=%b want 1/0", ok, out_update_ack);
        end
        for (int s = 1; s <= 20; s++) begin
            tick();
            checks++;
            if (out_an !== exp_an(s) || out_seg !== 8'hFF) begin
                errors++;
                $display("FAIL reset_mid_frame s=%0d an=%b seg=%h want %b/ff", s, out_an, out_seg, exp_an(s));
            end
        end
    endtask

    initial begin
        test_reset();
        test_update();
        test_overwrite();
        test_decode();
        test_boundary_update();
        test_blink();
        test_enable_drop();
        test_off_apply();
        test_zero_blank();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/digit_scan_driver.md
DIGIT_SCAN_DRIVER -- requirements
Module: digit_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: DRIVE cycles per digit slot, minimum 2.
REQ-002 SHALL have parameter BLANK_CYCLES, default 500: anode-off cycles before each digit slot, minimum 1.
REQ-003 SHALL have parameter BLINK_DIV, default 25000000: cycles per blink-phase toggle, minimum 2.
REQ-004 SHALL have port in_clock, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port in_reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have ports in_digit3..in_digit0, input, 4 bits each: BCD digits; digit3 is leftmost (out_an[3]).
REQ-007 SHALL have port in_update, input, 1 bit: one-cycle strobe that captures all four digits into the shadow register.
REQ-008 SHALL have port in_blink_mask, input, 4 bits: bit n set means digit n blinks.
REQ-009 SHALL have port in_enable, input, 1 bit: display on when high.
REQ-010 SHALL have port out_an, output, 4 bits: active-low anodes.
REQ-011 SHALL have port out_seg, output, 8 bits: active-low cathodes {dp,g,f,e,d,c,b,a}; dp is always 1.
REQ-012 SHALL have port out_update_ack, output, 1 bit: one-cycle pulse when shadow digits become active.
REQ-013 SHALL have port out_frame_start, output, 1 bit: one-cycle pulse when the digit3 slot begins.

Function
REQ-014 SHALL implement states OFF, BLANK, DRIVE and a 2-bit digit index counting down 3→0.
REQ-015 OFF: out_an=1111, out_seg=FF; the block SHALL go to BLANK with index 3 when in_enable=1.
REQ-016 BLANK: out_an=1111, out_seg=FF for BLANK_CYCLES cycles, then the block SHALL go to DRIVE.
REQ-017 DRIVE: the active-low one-hot anode for the index SHALL be asserted and out_seg SHALL show the decoded active digit for SCAN_DIV cycles.
REQ-018 DRIVE exit: if index≠0, index SHALL decrement and the block SHALL go to BLANK.
REQ-019 DRIVE exit at index 0: index SHALL reload to 3, the block SHALL go to BLANK, and out_frame_start SHALL pulse on entry to that BLANK.
REQ-020 in_enable=0 in any state SHALL force OFF on the next edge, with outputs blanked on that same edge.
REQ-021 out_an and out_seg SHALL be registered and change on the edge that changes state or index.
REQ-022 Decode SHALL map 0-9 to: C0 F9 A4 B0 99 92 82 F8 80 90; codes 10-15 SHALL map to FF.
REQ-023 Blink phase SHALL toggle every BLINK_DIV cycles, run free in all states, and start visible (1).
REQ-024 When a digit's in_blink_mask bit is 1 and phase is 0, out_seg SHALL be FF while its anode keeps its normal timing.
REQ-025 in_update SHALL overwrite the shadow digits and set pending; a later update before apply SHALL overwrite again.
REQ-026 Pending SHALL be applied at the DRIVE-exit-at-index-0 edge, with out_update_ack coincident with out_frame_start.
REQ-027 in_update on that same boundary edge SHALL apply the newly presented digits directly, ack once, and leave pending clear.
REQ-028 In OFF, pending SHALL apply on the next edge with out_update_ack pulsed.

Reset
REQ-029 Reset assertion SHALL immediately set: state OFF, index 3, out_an=1111, out_seg=FF, both pulses 0, pending 0, blink phase 1, all counters 0, shadow and active digits 4'hF.

Configuration
REQ-030 With SEG_LEADING_ZERO_BLANK_EN defined: digit3 SHALL be blank (FF) when 0, and digit2 SHALL be blank when digit3 and digit2 are both 0; digits 1 and 0 SHALL never be zero-suppressed.
REQ-031 Without SEG_LEADING_ZERO_BLANK_EN, zeros SHALL display as C0.

Structure
REQ-032 Package seg_pkg SHALL hold the state enum, the segment pattern constants, SEG_BLANK=8'hFF and BLANK_CODE=4'hF.
REQ-033 The combinational decode SHALL be sub-module seg_decoder, instantiated once on the indexed active digit.

Verification (SCAN_DIV=4, BLANK_CYCLES=1, BLINK_DIV=16)
REQ-034 Release reset with enable=1: out_an=1111 and out_seg=FF for one cycle, then out_an=0111 with out_seg=FF (digit 4'hF).
REQ-035 Update with 1,2,3,4 then wait two frames: ack coincides with frame_start; the sequence is 0111/F9, 1011/A4, 1101/B0, 1110/99, each 4 cycles separated by 1 blank cycle.
REQ-036 Blink mask 0011: digits 1 and 0 show FF for 16 cycles, then their codes for 16 cycles; anode timing is unchanged.
REQ-037 Drop enable mid-DRIVE: next edge gives 1111/FF; re-enable restarts at BLANK then digit3.
REQ-038 Assert reset mid-frame after an update: outputs blank immediately; after release the digits show FF until a new update.
REQ-039 Digits 0,0,0,7 with the macro defined: digits 3 and 2 show FF, digit1 C0, digit0 F8; without the macro, digits 3 and 2 show C0.
